// File: rtl/datapath_pkg.sv
// Shared constants for the bus datapath: ALU opcodes, fixed bus-source
// offsets (placed after the general registers) and the mul/div FSM states.
package datapath_pkg;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_SHR  = 4;
  localparam int OP_SHRA = 5;
  localparam int OP_SHL  = 6;
  localparam int OP_ROR  = 7;
  localparam int OP_ROL  = 8;
  localparam int OP_NEG  = 9;
  localparam int OP_NOT  = 10;
  localparam int OP_MUL  = 11;
  localparam int OP_DIV  = 12;

  localparam int SRC_HI     = 0;
  localparam int SRC_LO     = 1;
  localparam int SRC_ZHI    = 2;
  localparam int SRC_ZLO    = 3;
  localparam int SRC_PC     = 4;
  localparam int SRC_MDR    = 5;
  localparam int SRC_INPORT = 6;
  localparam int NSRC_FIX   = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative signed multiply / divide on operand magnitudes, one
// shift-add or restoring-subtract step per cycle, then a sign fix.
module muldiv_seq
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             wr_o,
  output logic             done_o,
  output logic             dz_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             div_q, sa_q, neg_q, bz_q;
  logic             done_q, dz_q;
  logic             take;

  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     rsh;
  logic               ge;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] prod, prod_s;

  assign take  = start_i && (state_q == ST_IDLE);
  assign add_s = {1'b0, acc_q} + (quo_q[0] ? {1'b0, b_q} : '0);
  assign rsh   = {acc_q, quo_q[WIDTH-1]};
  assign ge    = rsh >= {1'b0, b_q};
  assign diff  = WIDTH'(rsh - {1'b0, b_q});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          acc_d   = '0;
          quo_d   = mag(a_i);
        end
      end
      ST_RUN: begin
        if (div_q) begin
          acc_d = ge ? diff : rsh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ge};
        end else begin
          acc_d = add_s[WIDTH:1];
          quo_d = {add_s[0], quo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      neg_q   <= 1'b0;
      bz_q    <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      done_q  <= state_q == ST_FIX;
      dz_q    <= (state_q == ST_FIX) && div_q && bz_q;
      if (take) begin
        a_q   <= a_i;
        b_q   <= mag(b_i);
        div_q <= div_i;
        sa_q  <= a_i[WIDTH-1];
        neg_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
        bz_q  <= b_i == '0;
      end
    end
  end

  assign prod   = {acc_q, quo_q};
  assign prod_s = neg_q ? -prod : prod;

  // Remainder follows the dividend sign; zero divisor overrides both halves.
  always_comb begin
    hi_o = prod_s[2*WIDTH-1:WIDTH];
    lo_o = prod_s[WIDTH-1:0];
    if (div_q) begin
      hi_o = sa_q ? -acc_q : acc_q;
      lo_o = neg_q ? -quo_q : quo_q;
      if (bz_q) begin
        hi_o = a_q;
        lo_o = '1;
      end
    end
  end

  assign busy_o = state_q != ST_IDLE;
  assign wr_o   = state_q == ST_FIX;
  assign done_o = done_q;
  assign dz_o   = dz_q;

endmodule

// File: rtl/bus_datapath_p.sv
// Shared-bus CPU datapath: register file, priority bus mux, ALU with
// single-cycle ops and a sequenced signed multiply/divide engine.
module bus_datapath_p
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREG  = 16,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] mdata_in,
  input  logic [WIDTH-1:0] inport_in,
  input  logic [NREG-1:0]  reg_in,
  input  logic [NREG-1:0]  reg_out,
  input  logic             hi_in,
  input  logic             lo_in,
  input  logic             pc_in,
  input  logic             y_in,
  input  logic             mdr_in,
  input  logic             md_read,
  input  logic             hi_out,
  input  logic             lo_out,
  input  logic             zhi_out,
  input  logic             zlo_out,
  input  logic             pc_out,
  input  logic             mdr_out,
  input  logic             inport_out,
  input  logic [OPW-1:0]   opcode,
  input  logic             inc_pc,
  input  logic             alu_start,
  output logic             alu_busy,
  output logic             alu_done,
  output logic             div_zero,
  output logic             bus_conflict,
  output logic [WIDTH-1:0] bus_q,
  output logic [WIDTH-1:0] pc_q
);

  localparam int NSRC = NREG + NSRC_FIX;
  localparam int SW   = $clog2(WIDTH);

  logic [WIDTH-1:0] r_q [NREG];
  logic [WIDTH-1:0] hi_q, lo_q, y_q, mdr_q;
  logic [WIDTH-1:0] zhi_q, zlo_q, zhi_d, zlo_d;
  logic             sc_done_q;

  logic [NSRC-1:0]  sel;
  logic [WIDTH-1:0] src [NSRC];

  assign sel = {inport_out, mdr_out, pc_out, zlo_out,
                zhi_out, lo_out, hi_out, reg_out};

  always_comb begin
    for (int i = 0; i < NREG; i++) src[i] = r_q[i];
    src[NREG+SRC_HI]     = hi_q;
    src[NREG+SRC_LO]     = lo_q;
    src[NREG+SRC_ZHI]    = zhi_q;
    src[NREG+SRC_ZLO]    = zlo_q;
    src[NREG+SRC_PC]     = pc_q;
    src[NREG+SRC_MDR]    = mdr_q;
    src[NREG+SRC_INPORT] = inport_in;
  end

  // Scan from the top so the lowest asserted index ends up on the bus.
  always_comb begin
    bus_q = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (sel[i]) bus_q = src[i];
    end
  end

  assign bus_conflict = |(sel & (sel - NSRC'(1)));

  logic [WIDTH-1:0] a, b, alu_res;
  logic [SW-1:0]    sh;

  assign a  = y_q;
  assign b  = bus_q;
  assign sh = b[SW-1:0];

  always_comb begin
    alu_res = '0;
    unique case (opcode)
      OPW'(OP_ADD):  alu_res = a + b;
      OPW'(OP_SUB):  alu_res = a - b;
      OPW'(OP_AND):  alu_res = a & b;
      OPW'(OP_OR):   alu_res = a | b;
      OPW'(OP_SHR):  alu_res = a >> sh;
      OPW'(OP_SHRA): alu_res = $signed(a) >>> sh;
      OPW'(OP_SHL):  alu_res = a << sh;
      OPW'(OP_ROR):  alu_res = WIDTH'({a, a} >> sh);
      OPW'(OP_ROL):  alu_res = WIDTH'(({a, a} << sh) >> WIDTH);
      OPW'(OP_NEG):  alu_res = -b;
      OPW'(OP_NOT):  alu_res = ~b;
      default:       alu_res = '0;
    endcase
  end

  logic             md_op, accept, md_start, md_div;
  logic             md_wr, md_done, md_dz;
  logic [WIDTH-1:0] md_hi, md_lo;

  assign md_div   = opcode == OPW'(OP_DIV);
  assign md_op    = !inc_pc && (md_div || opcode == OPW'(OP_MUL));
  assign accept   = alu_start && !alu_busy;
  assign md_start = accept && md_op;

  muldiv_seq #(.WIDTH(WIDTH)) u_md (
    .clk     (clk),
    .rst_n   (clr),
    .start_i (md_start),
    .div_i   (md_div),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (alu_busy),
    .wr_o    (md_wr),
    .done_o  (md_done),
    .dz_o    (md_dz),
    .hi_o    (md_hi),
    .lo_o    (md_lo)
  );

  always_comb begin
    zhi_d = zhi_q;
    zlo_d = zlo_q;
    if (md_wr) begin
      zhi_d = md_hi;
      zlo_d = md_lo;
    end else if (accept && !md_op) begin
      zhi_d = '0;
      zlo_d = inc_pc ? bus_q + WIDTH'(1) : alu_res;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NREG; i++) r_q[i] <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pc_q      <= '0;
      y_q       <= '0;
      mdr_q     <= '0;
      zhi_q     <= '0;
      zlo_q     <= '0;
      sc_done_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (reg_in[i]) r_q[i] <= bus_q;
      end
      if (hi_in)  hi_q  <= bus_q;
      if (lo_in)  lo_q  <= bus_q;
      if (pc_in)  pc_q  <= bus_q;
      if (y_in)   y_q   <= bus_q;
      if (mdr_in) mdr_q <= md_read ? mdata_in : bus_q;
      zhi_q     <= zhi_d;
      zlo_q     <= zlo_d;
      sc_done_q <= accept && !md_op;
    end
  end

  assign alu_done = sc_done_q | md_done;
  assign div_zero = md_dz;

endmodule

// File: tb/tb_bus_datapath_p.sv
// Directed and random checks of bus_datapath_p against a plain-arithmetic
// reference model of the ALU, bus priority and multiply/divide results.
module tb_bus_datapath_p;

  localparam int W  = 32;
  localparam int NR = 16;
  localparam int OW = 5;

  logic          clk = 1'b0;
  logic          clr;
  logic [W-1:0]  mdata_in, inport_in;
  logic [NR-1:0] reg_in, reg_out;
  logic          hi_in, lo_in, pc_in, y_in, mdr_in, md_read;
  logic          hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out;
  logic [OW-1:0] opcode;
  logic          inc_pc, alu_start;
  logic          alu_busy, alu_done, div_zero, bus_conflict;
  logic [W-1:0]  bus_q, pc_q;

  int errors = 0;
  int checks = 0;

  bus_datapath_p #(.WIDTH(W), .NREG(NR), .OPW(OW)) dut (
    .clk(clk), .clr(clr), .mdata_in(mdata_in), .inport_in(inport_in),
    .reg_in(reg_in), .reg_out(reg_out), .hi_in(hi_in), .lo_in(lo_in),
    .pc_in(pc_in), .y_in(y_in), .mdr_in(mdr_in), .md_read(md_read),
    .hi_out(hi_out), .lo_out(lo_out), .zhi_out(zhi_out),
    .zlo_out(zlo_out), .pc_out(pc_out), .mdr_out(mdr_out),
    .inport_out(inport_out), .opcode(opcode), .inc_pc(inc_pc),
    .alu_start(alu_start), .alu_busy(alu_busy), .alu_done(alu_done),
    .div_zero(div_zero), .bus_conflict(bus_conflict),
    .bus_q(bus_q), .pc_q(pc_q)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_ctl();
    reg_in = '0; reg_out = '0;
    hi_in = 0; lo_in = 0; pc_in = 0; y_in = 0; mdr_in = 0; md_read = 0;
    hi_out = 0; lo_out = 0; zhi_out = 0; zlo_out = 0;
    pc_out = 0; mdr_out = 0; inport_out = 0;
    opcode = '0; inc_pc = 0; alu_start = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input int idx, input logic [W-1:0] v);
    inport_in = v; inport_out = 1; reg_in[idx] = 1'b1;
    tick(); clear_ctl();
  endtask

  task automatic load_y(input logic [W-1:0] v);
    inport_in = v; inport_out = 1; y_in = 1;
    tick(); clear_ctl();
  endtask

  task automatic read_z(output logic [W-1:0] hi, output logic [W-1:0] lo);
    zhi_out = 1; #1; hi = bus_q; zhi_out = 0;
    zlo_out = 1; #1; lo = bus_q; zlo_out = 0;
  endtask

  function automatic void model(input logic [4:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input bit inc,
                                output logic [W-1:0] zh,
                                output logic [W-1:0] zl, output bit dz);
    longint sa, sb, p;
    int s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = int'(b[4:0]);
    zh = '0; zl = '0; dz = 0;
    if (inc) zl = b + 1;
    else begin
      case (op)
        5'd0:  zl = a + b;
        5'd1:  zl = a - b;
        5'd2:  zl = a & b;
        5'd3:  zl = a | b;
        5'd4:  zl = a >> s;
        5'd5:  zl = $signed(a) >>> s;
        5'd6:  zl = a << s;
        5'd7: begin
          zl = a;
          for (int i = 0; i < s; i++) zl = {zl[0], zl[W-1:1]};
        end
        5'd8: begin
          zl = a;
          for (int i = 0; i < s; i++) zl = {zl[W-2:0], zl[W-1]};
        end
        5'd9:  zl = -b;
        5'd10: zl = ~b;
        5'd11: begin
          p = sa * sb; zh = p[63:32]; zl = p[31:0];
        end
        5'd12: begin
          if (b == '0) begin
            zl = '1; zh = a; dz = 1;
          end else begin
            p = sa / sb; zl = p[31:0];
            p = sa % sb; zh = p[31:0];
          end
        end
        default: ;
      endcase
    end
  endfunction

  // Runs one ALU op with Y=a and bus=b; checks latency and done pulse.
  task automatic do_op(input string tag, input logic [W-1:0] a,
                       input logic [4:0] op, input logic [W-1:0] b,
                       input bit inc, input int inj,
                       output logic [W-1:0] hi, output logic [W-1:0] lo,
                       output bit dz);
    int n;
    bit md;
    load_y(a);
    inport_in = b; inport_out = 1; opcode = op; inc_pc = inc;
    alu_start = 1;
    tick(); clear_ctl();
    n = 0;
    while (alu_busy && n < 100) begin
      if (n == inj) begin
        alu_start = 1; opcode = 5'd0; inport_in = ~b;
        inport_out = 1; y_in = 1;
      end
      tick(); clear_ctl();
      n++;
    end
    md = !inc && (op == 5'd11 || op == 5'd12);
    check({tag, "/busy_cycles"}, 64'(n), md ? 64'(W + 1) : 64'd0);
    check({tag, "/done"}, 64'(alu_done), 64'd1);
    dz = div_zero;
    read_z(hi, lo);
    tick();
    check({tag, "/done_end"}, 64'(alu_done), 64'd0);
  endtask

  logic [W-1:0] hi, lo, eh, el, a, b;
  logic [4:0]   op;
  bit           dz, edz, inc;
  int           dn;

  initial begin
    clear_ctl();
    clr = 0; mdata_in = '0; inport_in = '0;
    #12;
    check("rst/bus", 64'(bus_q), 64'd0);
    check("rst/pc", 64'(pc_q), 64'd0);
    check("rst/busy", 64'(alu_busy), 64'd0);
    check("rst/done", 64'(alu_done), 64'd0);
    check("rst/dz", 64'(div_zero), 64'd0);
    clr = 1;
    tick();

    mdata_in = 32'h22; md_read = 1; mdr_in = 1;
    tick(); clear_ctl();
    mdr_out = 1; reg_in[3] = 1;
    tick(); clear_ctl();
    reg_out[3] = 1; #1;
    check("xfer/r3", 64'(bus_q), 64'h22);
    check("xfer/conflict", 64'(bus_conflict), 64'd0);
    clear_ctl(); #1;
    check("idle/bus", 64'(bus_q), 64'd0);

    wr_reg(2, 32'hA);
    wr_reg(5, 32'hB);
    reg_out[2] = 1; reg_out[5] = 1; #1;
    check("conf/bus", 64'(bus_q), 64'hA);
    check("conf/flag", 64'(bus_conflict), 64'd1);
    clear_ctl();
    inport_in = 32'h5A5A; inport_out = 1; hi_in = 1; pc_out = 1; #1;
    check("conf2/flag", 64'(bus_conflict), 64'd1);
    tick(); clear_ctl();
    hi_out = 1; #1;
    check("hi/load_pc_prio", 64'(bus_q), 64'd0);
    clear_ctl();

    do_op("add", 32'd5, 5'd0, 32'hFFFFFFFE, 0, -1, hi, lo, dz);
    check("add/lo", 64'(lo), 64'd3);
    check("add/hi", 64'(hi), 64'd0);
    do_op("ror", 32'd1, 5'd7, 32'd1, 0, -1, hi, lo, dz);
    check("ror/lo", 64'(lo), 64'h80000000);

    do_op("mul", 32'hFFFFFFFA, 5'd11, 32'd7, 0, 4, hi, lo, dz);
    check("mul/hi", 64'(hi), 64'hFFFFFFFF);
    check("mul/lo", 64'(lo), 64'hFFFFFFD6);

    do_op("div", 32'hFFFFFFEF, 5'd12, 32'd5, 0, -1, hi, lo, dz);
    check("div/lo", 64'(lo), 64'hFFFFFFFD);
    check("div/hi", 64'(hi), 64'hFFFFFFFE);
    check("div/dz", 64'(dz), 64'd0);
    do_op("div0", 32'd9, 5'd12, 32'd0, 0, -1, hi, lo, dz);
    check("div0/lo", 64'(lo), 64'hFFFFFFFF);
    check("div0/hi", 64'(hi), 64'd9);
    check("div0/dz", 64'(dz), 64'd1);
    do_op("divmin", 32'h80000000, 5'd12, 32'hFFFFFFFF, 0, -1, hi, lo, dz);
    check("divmin/lo", 64'(lo), 64'h80000000);
    check("divmin/hi", 64'(hi), 64'd0);
    do_op("incpc", 32'd3, 5'd11, 32'h7FFFFFFF, 1, -1, hi, lo, dz);
    check("incpc/lo", 64'(lo), 64'h80000000);
    check("incpc/hi", 64'(hi), 64'd0);
    do_op("badop", 32'd3, 5'd14, 32'd9, 0, -1, hi, lo, dz);
    check("badop/lo", 64'(lo), 64'd0);

    for (int k = 0; k < 40; k++) begin
      a = $urandom; b = $urandom;
      op = 5'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) b = -b;
      inc = $urandom_range(0, 7) == 0;
      model(op, a, b, inc, eh, el, edz);
      do_op($sformatf("rnd%0d_op%0d", k, op), a, op, b, inc, -1, hi, lo, dz);
      check($sformatf("rnd%0d/hi", k), 64'(hi), 64'(eh));
      check($sformatf("rnd%0d/lo", k), 64'(lo), 64'(el));
      check($sformatf("rnd%0d/dz", k), 64'(dz), 64'(edz));
    end

    wr_reg(1, 32'h1234);
    inport_in = 32'h40; inport_out = 1; pc_in = 1;
    tick(); clear_ctl();
    check("pc/load", 64'(pc_q), 64'h40);
    load_y(32'd3);
    inport_in = 32'd7; inport_out = 1; opcode = 5'd11; alu_start = 1;
    tick(); clear_ctl();
    repeat (5) tick();
    check("abort/busy_before", 64'(alu_busy), 64'd1);
    #2 clr = 0;
    #1;
    check("abort/busy", 64'(alu_busy), 64'd0);
    check("abort/done", 64'(alu_done), 64'd0);
    check("abort/pc", 64'(pc_q), 64'd0);
    read_z(hi, lo);
    check("abort/zhi", 64'(hi), 64'd0);
    check("abort/zlo", 64'(lo), 64'd0);
    reg_out[1] = 1; #1;
    check("abort/r1", 64'(bus_q), 64'd0);
    clear_ctl();
    reg_out[3] = 1; #1;
    check("abort/r3", 64'(bus_q), 64'd0);
    clear_ctl();
    clr = 1;
    dn = 0;
    repeat (40) begin
      tick();
      if (alu_done) dn++;
    end
    check("abort/no_done", 64'(dn), 64'd0);
    read_z(hi, lo);
    check("abort/zlo_after", 64'(lo), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_datapath_p.md
Name: bus_datapath_p

Overview:
Parametrised next-generation CPU datapath: NREG general registers, plus HI, LO, PC, Y, MDR and the Z_HI/Z_LO pair, all on one shared WIDTH-bit bus.
Bus source is chosen by one-hot drive selects through a priority encoder, and multiple drivers are flagged.
The ALU takes operand A from Y and operand B from the bus, and writes Z.
It adds an iterative signed multiply/divide engine with a start/busy/done handshake, so the control unit can run multi-cycle ops.

Parameters:
WIDTH, 32, datapath/register width (even, >=8)
NREG, 16, number of general registers (2..32)
OPW, 5, opcode width

Ports:
clk  in  1  clock, rising edge
clr  in  1  reset, asynchronous, active-low
mdata_in  in  WIDTH  memory read data into MDR
inport_in  in  WIDTH  input-port value, bus source
reg_in  in  NREG  per-register write enables (multiple allowed)
reg_out  in  NREG  per-register bus drive selects
hi_in, lo_in, pc_in, y_in, mdr_in  in  1  write enables from bus (MDR source per md_read)
md_read  in  1  1: MDR loads mdata_in; 0: MDR loads bus
hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out  in  1  bus drive selects
opcode  in  OPW  ALU operation, sampled only with alu_start
inc_pc  in  1  with alu_start: Z_LO=bus+1, Z_HI=0, opcode ignored
alu_start  in  1  start pulse; ignored while alu_busy
alu_busy  out  1  multi-cycle op in progress
alu_done  out  1  one-cycle pulse, Z result valid
div_zero  out  1  pulses with alu_done when DIV divisor was 0
bus_conflict  out  1  combinational, >1 drive select asserted
bus_q  out  WIDTH  current bus value
pc_q  out  WIDTH  PC contents

Behaviour:
- Reset (clr=0, async): all registers, Z, and the sequencer go to 0; state IDLE; alu_busy, alu_done and div_zero are 0. Reset mid-operation aborts the operation with no Z write.
- Bus priority, lowest index wins: R0..R(NREG-1), HI, LO, ZHI, ZLO, PC, MDR, INPORT. With no select asserted, bus=0.
- Register writes happen at the rising edge when the enable is high. A register may drive the bus and load in the same cycle; it loads the pre-edge bus value.
- Opcodes: 0 ADD, 1 SUB(A-B), 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG(-B), 10 NOT(~B), 11 MUL, 12 DIV. Any other opcode gives Z=0.
- Shift and rotate amount is B[log2(WIDTH)-1:0], shifting A.
- Single-cycle ops: Z_LO=result, Z_HI=0, both written at the edge that samples alu_start. alu_done pulses the next cycle. alu_busy stays 0.
- FSM IDLE->RUN->FIX->IDLE, used by MUL and DIV only.
- Start edge E0: latch |A|, |B| and the result signs; enter RUN; alu_busy=1.
- Edges E1..E_WIDTH: one shift-add (MUL) or restoring-subtract (DIV) iteration each.
- Edge E(WIDTH+1): apply the sign fix, write Z, clear alu_busy, pulse alu_done for one cycle. alu_busy is high for WIDTH+1 cycles.
- MUL result: signed 2*WIDTH product, Z_HI upper half, Z_LO lower half.
- DIV result: Z_LO = quotient truncated toward zero; Z_HI = remainder carrying the dividend's sign.
- DIV by zero: full latency; Z_LO=all ones, Z_HI=A; div_zero pulses with alu_done.
- The most-negative divided by -1 wraps: Z_LO=A, Z_HI=0.
- alu_start while busy is ignored and does not change opcode or operands.
- Y and bus may change during RUN without effect.
- alu_start together with inc_pc behaves as a single-cycle op.

Decomposition:
- Package datapath_pkg: opcode localparams (OP_ADD..OP_DIV), bus-source index constants, FSM state encoding.
- Sub-module muldiv_seq (WIDTH), implementing RUN/FIX with start/busy/done.

Test Plan:
- Reset: drop clr mid-MUL -> alu_busy=0, Z_HI=Z_LO=0, all registers 0, no alu_done.
- Transfer: mdata_in=0x00000022, md_read=1, mdr_in; next cycle mdr_out+reg_in[3] -> R3=0x22, bus_conflict=0.
- Conflict: R2=0xA, R5=0xB, reg_out[2]&reg_out[5] -> bus_q=0xA, bus_conflict=1.
- ADD then ROR: Y=5, bus=0xFFFFFFFE, ADD -> next cycle Z_LO=3, alu_done=1. Then Y=0x1, bus=1, ROR -> Z_LO=0x80000000.
- MUL: Y=0xFFFFFFFA, bus=7 -> alu_busy high 33 cycles, then Z_HI=0xFFFFFFFF, Z_LO=0xFFFFFFD6. A second alu_start at cycle 5 is ignored.
- DIV: Y=-17, bus=5 -> Z_LO=0xFFFFFFFD, Z_HI=0xFFFFFFFE. Y=9, bus=0 -> Z_LO=0xFFFFFFFF, Z_HI=9, div_zero=1.
